// File: rtl/multi_point_controller.sv
// Button-driven x/y/z position source for NUM_POINTS tracked points.
// Raw buttons are synchronised and debounced; held direction buttons auto-repeat and coordinates saturate.
module multi_point_controller #(
    parameter int NUM_POINTS      = 5,
    parameter int XY_W            = 12,
    parameter int Z_W             = 14,
    parameter int STEP            = 4,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int Z_MAX           = 8191,
    parameter int X_INIT          = 512,
    parameter int Y_INIT          = 384,
    parameter int Z_INIT          = 1024,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 26000000,
    parameter int REPEAT_CYCLES   = 6500000,
    localparam int SEL_W          = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_sel,
    input  logic                       mode_z,
    output logic [NUM_POINTS*XY_W-1:0] x_out,
    output logic [NUM_POINTS*XY_W-1:0] y_out,
    output logic [NUM_POINTS*Z_W-1:0]  z_out,
    output logic [SEL_W-1:0]           sel_out,
    output logic                       update_out
);
    localparam int NB      = 5;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int EV_L = 0, EV_R = 1, EV_U = 2, EV_D = 3, EV_SEL = 4, IN_MODE = 5;

    localparam logic signed [XY_W+1:0] STEP_XY = (XY_W+2)'(STEP);
    localparam logic signed [XY_W+1:0] X_HI    = (XY_W+2)'(X_MAX);
    localparam logic signed [XY_W+1:0] Y_HI    = (XY_W+2)'(Y_MAX);
    localparam logic signed [Z_W+1:0]  STEP_Z  = (Z_W+2)'(STEP);
    localparam logic signed [Z_W+1:0]  Z_HI    = (Z_W+2)'(Z_MAX);

    logic [5:0]       meta_q, meta_d, sync_q, sync_d;
    logic [NB-1:0]    deb_q, deb_d, prev_q, prev_d;
    logic [DB_W-1:0]  db_cnt_q [NB];
    logic [DB_W-1:0]  db_cnt_d [NB];
    logic [REP_W-1:0] rep_cnt_q [4];
    logic [REP_W-1:0] rep_cnt_d [4];
    logic [3:0]       rep_first_q, rep_first_d;
    logic [XY_W-1:0]  x_q [NUM_POINTS];
    logic [XY_W-1:0]  x_d [NUM_POINTS];
    logic [XY_W-1:0]  y_q [NUM_POINTS];
    logic [XY_W-1:0]  y_d [NUM_POINTS];
    logic [Z_W-1:0]   z_q [NUM_POINTS];
    logic [Z_W-1:0]   z_d [NUM_POINTS];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             update_q, update_d;

    logic [NB-1:0]         rise;
    logic [3:0]            ev;
    logic                  up_only, down_only;
    logic signed [XY_W+1:0] xe, ye;
    logic signed [Z_W+1:0]  ze;

    // Intermediate sums carry a sign bit plus one guard bit so both bounds are visible.
    function automatic logic [XY_W-1:0] clamp_xy(input logic signed [XY_W+1:0] v,
                                                 input logic signed [XY_W+1:0] hi);
        logic [XY_W-1:0] r;
        if (v < 0)       r = '0;
        else if (v > hi) r = hi[XY_W-1:0];
        else             r = v[XY_W-1:0];
        return r;
    endfunction

    function automatic logic [Z_W-1:0] clamp_z(input logic signed [Z_W+1:0] v,
                                               input logic signed [Z_W+1:0] hi);
        logic [Z_W-1:0] r;
        if (v < 0)       r = '0;
        else if (v > hi) r = hi[Z_W-1:0];
        else             r = v[Z_W-1:0];
        return r;
    endfunction

    always_comb begin
        meta_d      = {mode_z, btn_sel, btn_down, btn_up, btn_right, btn_left};
        sync_d      = meta_q;
        rise        = deb_q & ~prev_q;
        prev_d      = deb_q;
        deb_d       = deb_q;
        rep_first_d = rep_first_q;
        ev          = '0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        sel_d       = sel_q;
        update_d    = 1'b0;
        xe          = '0;
        ye          = '0;
        ze          = '0;

        for (int i = 0; i < NB; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync_q[i];
                else                                         db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end

        // First repeat waits REPEAT_DELAY after the press step, later ones REPEAT_CYCLES.
        for (int j = 0; j < 4; j++) begin
            rep_cnt_d[j] = '0;
            if (!deb_q[j]) begin
                rep_first_d[j] = 1'b1;
            end else if (rise[j]) begin
                ev[j] = 1'b1;
            end else if (rep_cnt_q[j] == REP_W'(rep_first_q[j] ? REPEAT_DELAY - 1 : REPEAT_CYCLES - 1)) begin
                ev[j]          = 1'b1;
                rep_first_d[j] = 1'b0;
            end else begin
                rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
            end
        end

        up_only   = ev[EV_U] & ~ev[EV_D];
        down_only = ev[EV_D] & ~ev[EV_U];

        for (int p = 0; p < NUM_POINTS; p++) begin
            if (sel_q == SEL_W'(p)) begin
                xe = $signed({2'b00, x_q[p]});
                ye = $signed({2'b00, y_q[p]});
                ze = $signed({2'b00, z_q[p]});
                if (ev[EV_R] && !ev[EV_L])      x_d[p] = clamp_xy(xe + STEP_XY, X_HI);
                else if (ev[EV_L] && !ev[EV_R]) x_d[p] = clamp_xy(xe - STEP_XY, X_HI);
                if (sync_q[IN_MODE]) begin
                    if (up_only)        z_d[p] = clamp_z(ze + STEP_Z, Z_HI);
                    else if (down_only) z_d[p] = clamp_z(ze - STEP_Z, Z_HI);
                end else begin
                    if (up_only)        y_d[p] = clamp_xy(ye - STEP_XY, Y_HI);
                    else if (down_only) y_d[p] = clamp_xy(ye + STEP_XY, Y_HI);
                end
                update_d = (x_d[p] != x_q[p]) | (y_d[p] != y_q[p]) | (z_d[p] != z_q[p]);
            end
        end

        if (rise[EV_SEL]) sel_d = (sel_q == SEL_W'(NUM_POINTS - 1)) ? '0 : sel_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_q      <= '0;
            sync_q      <= '0;
            deb_q       <= '0;
            prev_q      <= '0;
            rep_first_q <= '1;
            sel_q       <= '0;
            update_q    <= 1'b0;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
            for (int j = 0; j < 4; j++)  rep_cnt_q[j] <= '0;
            for (int p = 0; p < NUM_POINTS; p++) begin
                x_q[p] <= XY_W'(X_INIT);
                y_q[p] <= XY_W'(Y_INIT);
                z_q[p] <= Z_W'(Z_INIT);
            end
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            prev_q      <= prev_d;
            rep_first_q <= rep_first_d;
            sel_q       <= sel_d;
            update_q    <= update_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
        end
    end

    always_comb begin
        x_out = '0;
        y_out = '0;
        z_out = '0;
        for (int p = 0; p < NUM_POINTS; p++) begin
            x_out[p*XY_W +: XY_W] = x_q[p];
            y_out[p*XY_W +: XY_W] = y_q[p];
            z_out[p*Z_W +: Z_W]   = z_q[p];
        end
    end

    assign sel_out    = sel_q;
    assign update_out = update_q;

endmodule

// File: tb/tb_multi_point_controller.sv
// Directed bench for multi_point_controller with short debounce/repeat timing and three points.
module tb_multi_point_controller;
    localparam int NP   = 3;
    localparam int XY_W = 12;
    localparam int Z_W  = 14;

    logic clk = 1'b0;
    logic rst_n;
    logic bl, br, bu, bd, bs, mz;
    logic [NP*XY_W-1:0] x_out, y_out;
    logic [NP*Z_W-1:0]  z_out;
    logic [1:0]         sel_out;
    logic               upd;

    int checks = 0;
    int passed = 0;

    multi_point_controller #(
        .NUM_POINTS(NP), .XY_W(XY_W), .Z_W(Z_W), .STEP(4),
        .X_MAX(1023), .Y_MAX(767), .Z_MAX(8191),
        .X_INIT(512), .Y_INIT(384), .Z_INIT(1024),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_CYCLES(8)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .btn_sel(bs), .mode_z(mz),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .sel_out(sel_out), .update_out(upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]         btn;   // {mode, sel, down, up, right, left}
        int                 hold;
        logic [NP*XY_W-1:0] ex;
        logic [NP*XY_W-1:0] ey;
        logic [NP*Z_W-1:0]  ez;
        logic [1:0]         es;
        int                 eu;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [NP*XY_W-1:0] pkxy(input int a, input int b, input int c);
        return {XY_W'(c), XY_W'(b), XY_W'(a)};
    endfunction

    function automatic logic [NP*Z_W-1:0] pkz(input int a, input int b, input int c);
        return {Z_W'(c), Z_W'(b), Z_W'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_btn(input logic [5:0] b);
        {mz, bs, bd, bu, br, bl} = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_init(input string tag);
        chk({tag, "_x"}, 64'(x_out), 64'(pkxy(512, 512, 512)));
        chk({tag, "_y"}, 64'(y_out), 64'(pkxy(384, 384, 384)));
        chk({tag, "_z"}, 64'(z_out), 64'(pkz(1024, 1024, 1024)));
        chk({tag, "_sel"}, 64'(sel_out), 64'd0);
        chk({tag, "_upd"}, 64'(upd), 64'd0);
    endtask

    task automatic idle(input int n);
        set_btn(6'b0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int updc;
        int k;
        set_btn(6'b0);
        do_reset();
        check_init("reset");

        // Single right press: step lands on the 7th edge after the press.
        set_btn(6'b000010);
        updc = 0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            updc += int'(upd);
            if (e == 6) begin
                chk("a_x_before", 64'(x_out[11:0]), 64'd512);
                chk("a_upd_before", 64'(upd), 64'd0);
            end
            if (e == 7) begin
                chk("a_x_step", 64'(x_out[11:0]), 64'd516);
                chk("a_upd_step", 64'(upd), 64'd1);
            end
            if (e == 8) chk("a_upd_after", 64'(upd), 64'd0);
        end
        idle(14);
        chk("a_updcount", 64'(updc), 64'd1);
        chk("a_x_all", 64'(x_out), 64'(pkxy(516, 512, 512)));
        chk("a_y_all", 64'(y_out), 64'(pkxy(384, 384, 384)));
        chk("a_z_all", 64'(z_out), 64'(pkz(1024, 1024, 1024)));

        vecs[0]  = '{6'b000011, 10, pkxy(516, 512, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd0, 0};
        vecs[1]  = '{6'b001000,  3, pkxy(516, 512, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd0, 0};
        vecs[2]  = '{6'b000100, 10, pkxy(516, 512, 512), pkxy(380, 384, 384), pkz(1024, 1024, 1024), 2'd0, 1};
        vecs[3]  = '{6'b001000, 10, pkxy(516, 512, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd0, 1};
        vecs[4]  = '{6'b001100, 10, pkxy(516, 512, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd0, 0};
        vecs[5]  = '{6'b010000, 10, pkxy(516, 512, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd1, 0};
        vecs[6]  = '{6'b000010, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd1, 1};
        vecs[7]  = '{6'b100100, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1028, 1024), 2'd1, 1};
        vecs[8]  = '{6'b101000, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd1, 1};
        vecs[9]  = '{6'b010000, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1024), 2'd2, 0};
        vecs[10] = '{6'b100100, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1028), 2'd2, 1};
        vecs[11] = '{6'b010000, 10, pkxy(516, 516, 512), pkxy(384, 384, 384), pkz(1024, 1024, 1028), 2'd0, 0};

        for (int v = 0; v < 12; v++) begin
            set_btn(vecs[v].btn);
            updc = 0;
            repeat (vecs[v].hold) begin
                @(negedge clk);
                updc += int'(upd);
            end
            set_btn(6'b0);
            repeat (14) begin
                @(negedge clk);
                updc += int'(upd);
            end
            chk($sformatf("v%0d_x", v), 64'(x_out), 64'(vecs[v].ex));
            chk($sformatf("v%0d_y", v), 64'(y_out), 64'(vecs[v].ey));
            chk($sformatf("v%0d_z", v), 64'(z_out), 64'(vecs[v].ez));
            chk($sformatf("v%0d_sel", v), 64'(sel_out), 64'(vecs[v].es));
            chk($sformatf("v%0d_upd", v), 64'(updc), 64'(vecs[v].eu));
        end

        // Walk point0 down to x=8, then a fresh left press runs into the lower bound.
        set_btn(6'b000001);
        k = 0;
        while (x_out[11:0] != 12'd8 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        idle(14);
        chk("b_reach8", 64'(x_out[11:0]), 64'd8);

        set_btn(6'b000001);
        updc = 0;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            updc += int'(upd);
            if (e == 6)  chk("b_x_e6", 64'(x_out[11:0]), 64'd8);
            if (e == 7)  chk("b_x_e7", 64'(x_out[11:0]), 64'd4);
            if (e == 26) chk("b_x_e26", 64'(x_out[11:0]), 64'd4);
            if (e == 27) begin
                chk("b_x_e27", 64'(x_out[11:0]), 64'd0);
                chk("b_upd_e27", 64'(upd), 64'd1);
            end
        end
        chk("b_x_final", 64'(x_out[11:0]), 64'd0);
        chk("b_updcount", 64'(updc), 64'd2);
        idle(14);

        // Sel and right step on the same cycle: move uses the old selection.
        set_btn(6'b010010);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 6) begin
                chk("c_x0_e6", 64'(x_out[11:0]), 64'd0);
                chk("c_sel_e6", 64'(sel_out), 64'd0);
            end
            if (e == 7) begin
                chk("c_x0_e7", 64'(x_out[11:0]), 64'd4);
                chk("c_sel_e7", 64'(sel_out), 64'd1);
                chk("c_x1_e7", 64'(x_out[23:12]), 64'd516);
            end
        end
        idle(14);

        // Reset in the middle of a hold on point1 at x=600.
        do_reset();
        check_init("reset2");
        set_btn(6'b010000);
        repeat (10) @(negedge clk);
        idle(14);
        chk("d_sel1", 64'(sel_out), 64'd1);
        set_btn(6'b000010);
        k = 0;
        while (x_out[23:12] != 12'd600 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("d_reach600", 64'(x_out[23:12]), 64'd600);
        #2 rst_n = 1'b0;
        #1 check_init("d_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        updc = 0;
        for (int e = 1; e <= 27; e++) begin
            @(negedge clk);
            updc += int'(upd);
            if (e == 6)  chk("d_x0_e6", 64'(x_out[11:0]), 64'd512);
            if (e == 7)  chk("d_x0_e7", 64'(x_out[11:0]), 64'd516);
            if (e == 26) begin
                chk("d_x0_e26", 64'(x_out[11:0]), 64'd516);
                chk("d_updcount", 64'(updc), 64'd1);
            end
            if (e == 27) chk("d_x0_e27", 64'(x_out[11:0]), 64'd520);
        end
        chk("d_x1_held", 64'(x_out[23:12]), 64'd512);
        idle(14);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
